lenet_layer_sched: RTL and testbench

//  Top-level layer sequencer for the LeNet engine. Accepts one input frame, then starts each layer

---
 rtl/lenet_layer_sched_pkg.sv | 18 +
 rtl/lenet_wdog.sv | 23 ++
 rtl/lenet_layer_sched.sv | 106 ++++++++++
 tb/tb_lenet_layer_sched.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lenet_layer_sched_pkg.sv
// Shared encodings for the LeNet layer sequencer: one-hot scheduler states and layer indices.
package lenet_layer_sched_pkg;

  typedef enum logic [4:0] {
    SCH_IDLE   = 5'b00001,
    SCH_START  = 5'b00010,
    SCH_WAIT   = 5'b00100,
    SCH_RESULT = 5'b01000,
    SCH_ERR    = 5'b10000
  } sch_state_e;

  localparam int unsigned L_CONV1 = 0;
  localparam int unsigned L_POOL1 = 1;
  localparam int unsigned L_CONV2 = 2;
  localparam int unsigned L_POOL2 = 3;
  localparam int unsigned L_FC    = 4;

endpackage

// File: rtl/lenet_wdog.sv
// Per-layer watchdog: load clears, enable counts up, expire flags the last allowed cycle.
module lenet_wdog #(
  parameter int W     = 16,
  parameter int LIMIT = 40000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/lenet_layer_sched.sv
// LeNet layer sequencer: runs layers 0..NUM_LAYERS-1 per frame, then a result handshake.
// Optional watchdog per layer under macro LAYER_TIMEOUT_EN.
module lenet_layer_sched
  import lenet_layer_sched_pkg::*;
#(
  parameter int NUM_LAYERS  = 5,
  parameter int IDX_W       = 3,
  parameter int FRAME_CNT_W = 16,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [NUM_LAYERS-1:0]  layer_start,
  input  logic [NUM_LAYERS-1:0]  layer_done,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy,
  output logic [IDX_W-1:0]       cur_layer,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_unexp_done,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  sch_state_e            state;
  logic [IDX_W-1:0]      idx;
  logic [NUM_LAYERS-1:0] idx_oh;
  logic                  done_cur, stray, expire, timeout;

  assign idx_oh   = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << idx;
  assign done_cur = (state == SCH_WAIT) && |(layer_done & idx_oh);
  // Only the expected layer's done is legal, and only while waiting on it.
  assign stray    = (state == SCH_WAIT) ? |(layer_done & ~idx_oh) : |layer_done;

`ifdef LAYER_TIMEOUT_EN
  lenet_wdog #(.W(TIMEOUT_W), .LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .load   (state == SCH_START),
    .en     (state == SCH_WAIT),
    .expire (expire)
  );

  logic tmo;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tmo <= 1'b0;
    else if (timeout) tmo <= 1'b1;
    else if (err_clr) tmo <= 1'b0;
  end
  assign timeout_err = tmo;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A done on the expiry cycle wins over the watchdog.
  assign timeout = (state == SCH_WAIT) && expire && !done_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SCH_IDLE;
      idx            <= '0;
      frame_cnt      <= '0;
      err_unexp_done <= 1'b0;
    end else begin
      if (stray)        err_unexp_done <= 1'b1;
      else if (err_clr) err_unexp_done <= 1'b0;
      case (state)
        SCH_IDLE: if (frame_valid) begin
          idx   <= '0;
          state <= SCH_START;
        end
        SCH_START: state <= SCH_WAIT;
        SCH_WAIT: begin
          if (done_cur) begin
            if (idx == IDX_W'(NUM_LAYERS - 1)) state <= SCH_RESULT;
            else begin
              idx   <= idx + 1'b1;
              state <= SCH_START;
            end
          end else if (timeout) state <= SCH_ERR;
        end
        SCH_RESULT: if (result_ready) begin
          frame_cnt <= frame_cnt + 1'b1;
          idx       <= '0;
          state     <= SCH_IDLE;
        end
        SCH_ERR: if (err_clr) begin
          idx   <= '0;
          state <= SCH_IDLE;
        end
        default: state <= SCH_IDLE;
      endcase
    end
  end

  assign frame_ready  = (state == SCH_IDLE);
  assign layer_start  = (state == SCH_START) ? idx_oh : '0;
  assign result_valid = (state == SCH_RESULT);
  assign busy         = (state == SCH_START) || (state == SCH_WAIT) || (state == SCH_RESULT);
  assign cur_layer    = idx;

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Bench for lenet_layer_sched: randomized layer latencies and back-pressure against a frame-level model.
module tb_lenet_layer_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_valid = 1'b0;
  logic       frame_ready;
  logic [4:0] layer_start;
  logic [4:0] layer_done = '0;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic       busy;
  logic [2:0] cur_layer;
  logic [1:0] frame_cnt;
  logic       err_unexp_done;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  lenet_layer_sched #(.FRAME_CNT_W(2), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .layer_start(layer_start), .layer_done(layer_done), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy), .cur_layer(cur_layer), .frame_cnt(frame_cnt),
    .err_unexp_done(err_unexp_done), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full frame; each done arrives gap cycles after its start, result held bp cycles.
  task automatic run_frame(input int gap, input int bp, input int stray_layer, input logic [4:0] stray_mask);
    logic [4:0] exp_ls;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_ls = 5'd1 << k;
      total++; if (layer_start !== exp_ls) begin bad++; $display("FAIL start[%0d]: got %b want %b", k, layer_start, exp_ls); end
      total++; if (cur_layer !== 3'(k) || busy !== 1'b1) begin bad++; $display("FAIL cur_layer[%0d]: got %0d busy %b want %0d busy 1", k, cur_layer, busy, k); end
      step();
      for (int i = 0; i < gap - 1; i++) begin
        total++; if (layer_start !== 5'd0 || result_valid !== 1'b0) begin bad++; $display("FAIL wait[%0d]: start %b rv %b want 0 0", k, layer_start, result_valid); end
        layer_done = (k == stray_layer && i == 0) ? stray_mask : 5'd0;
        step();
      end
      layer_done = exp_ls;
      step();
      layer_done = 5'd0;
    end
    total++; if (result_valid !== 1'b1 || cur_layer !== 3'd4 || layer_start !== 5'd0) begin bad++; $display("FAIL result: rv %b cur %0d start %b want 1 4 0", result_valid, cur_layer, layer_start); end
    for (int i = 0; i < bp; i++) begin
      step();
      total++; if (result_valid !== 1'b1 || frame_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL backpressure: rv %b fr %b busy %b want 1 0 1", result_valid, frame_ready, busy); end
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 4;
    total++; if (frame_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin bad++; $display("FAIL idle: fr %b busy %b rv %b want 1 0 0", frame_ready, busy, result_valid); end
    total++; if (frame_cnt !== 2'(exp_cnt)) begin bad++; $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  // Start a frame and advance without checks until layer n has just been started.
  task automatic to_layer(input int n);
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      layer_done = 5'd1 << k;
      step();
      layer_done = 5'd0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (frame_ready !== 1'b1 || layer_start !== 5'd0 || result_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ctl: fr %b start %b rv %b busy %b want 1 0 0 0", frame_ready, layer_start, result_valid, busy); end
    total++; if (cur_layer !== 3'd0 || frame_cnt !== 2'd0 || err_unexp_done !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL reset_state: cur %0d cnt %0d eu %b to %b want 0 0 0 0", cur_layer, frame_cnt, err_unexp_done, timeout_err); end
    rst = 1'b0;
    exp_cnt = 0;
    step();
  endtask

  task automatic test_normal();
    run_frame(20, 0, -1, 5'd0);
    total++; if (err_unexp_done !== 1'b0) begin bad++; $display("FAIL normal_err: got %b want 0", err_unexp_done); end
  endtask

  task automatic test_back_to_back();
    run_frame(int'($urandom_range(1, 8)), 50, -1, 5'd0);
    run_frame(int'($urandom_range(1, 8)), int'($urandom_range(0, 4)), -1, 5'd0);
  endtask

  task automatic test_stray();
    run_frame(int'($urandom_range(2, 10)), 2, 1, 5'b01000);
    total++; if (err_unexp_done !== 1'b1) begin bad++; $display("FAIL stray_set: got %b want 1", err_unexp_done); end
    err_clr = 1'b1;
    layer_done = 5'b00001;
    step();
    err_clr = 1'b0;
    layer_done = 5'd0;
    total++; if (err_unexp_done !== 1'b1 || frame_ready !== 1'b1) begin bad++; $display("FAIL stray_set_wins: eu %b fr %b want 1 1", err_unexp_done, frame_ready); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++; if (err_unexp_done !== 1'b0) begin bad++; $display("FAIL stray_clr: got %b want 0", err_unexp_done); end
  endtask

  task automatic test_reset_mid();
    to_layer(2);
    step();
    step();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || frame_ready !== 1'b1 || layer_start !== 5'd0 || cur_layer !== 3'd0 || frame_cnt !== 2'd0) begin bad++; $display("FAIL reset_mid: busy %b fr %b start %b cur %0d cnt %0d want 0 1 0 0 0", busy, frame_ready, layer_start, cur_layer, frame_cnt); end
    step();
    rst = 1'b0;
    exp_cnt = 0;
    step();
    total++; if (layer_start !== 5'd0 || result_valid !== 1'b0) begin bad++; $display("FAIL reset_no_pulse: start %b rv %b want 0 0", layer_start, result_valid); end
    run_frame(int'($urandom_range(1, 6)), 0, -1, 5'd0);
  endtask

  task automatic test_timeout();
`ifdef LAYER_TIMEOUT_EN
    to_layer(2);
    step();
    for (int i = 0; i < 99; i++) step();
    total++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early: busy %b to %b want 1 0", busy, timeout_err); end
    step();
    total++; if (timeout_err !== 1'b1 || busy !== 1'b0 || frame_ready !== 1'b0) begin bad++; $display("FAIL tmo_err: to %b busy %b fr %b want 1 0 0", timeout_err, busy, frame_ready); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++; if (timeout_err !== 1'b0 || frame_ready !== 1'b1) begin bad++; $display("FAIL tmo_clr: to %b fr %b want 0 1", timeout_err, frame_ready); end
`endif
    run_frame(100, 0, -1, 5'd0);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_edge_done: got %b want 0", timeout_err); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    step();
    for (int f = 0; f < 5; f++)
      run_frame(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), -1, 5'd0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_back_to_back();
    test_stray();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
